// File: rtl/uart_command_parser.sv
// Byte-stream command parser: hunts for a fixed header, decodes a two-byte
// command word, then forwards a fixed-length payload with an inter-byte timeout.
module uart_command_parser #(
  parameter int                          HEADER_BYTES   = 2,
  parameter logic [8*HEADER_BYTES-1:0]   HEADER         = 16'hCDBA,
  parameter logic [7:0]                  CMD_TAG        = 8'hA0,
  parameter int                          NUM_CMDS       = 6,
  parameter int                          PAYLOAD_BYTES  = 1024,
  parameter int                          TIMEOUT_CYCLES = 100000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] rx_data,
  input  logic       rx_valid,
  output logic       cmd_valid,
  output logic [3:0] cmd_id,
  output logic       cmd_error,
  output logic [7:0] payload_data,
  output logic       payload_valid,
  output logic       payload_last,
  output logic       busy,
  output logic       timeout
);

  localparam int              PCW       = (PAYLOAD_BYTES > 0) ? $clog2(PAYLOAD_BYTES + 1) : 1;
  localparam int              ICW       = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [PCW-1:0]  PAY_LAST  = (PAYLOAD_BYTES > 0) ? PCW'(PAYLOAD_BYTES - 1) : '0;
  localparam logic [ICW-1:0]  IDLE_LAST = (TIMEOUT_CYCLES > 0) ? ICW'(TIMEOUT_CYCLES - 1) : '0;
  localparam logic [1:0]      HDR_LAST  = 2'(HEADER_BYTES - 1);
  localparam logic [3:0]      NCMD      = 4'(NUM_CMDS);
  // Header left-aligned in 32 bits so byte i (MSB first) is always bits [31-8i -: 8].
  localparam logic [31:0]     HDR_ALIGN = 32'(HEADER) << (8 * (4 - HEADER_BYTES));
  localparam logic [7:0]      HDR_FIRST = HDR_ALIGN[31:24];

  typedef enum logic [1:0] {S_HDR, S_CMD, S_PAYLOAD} state_t;

  state_t         r_state;
  logic           r_rst_sync;
  logic [1:0]     r_hdr_cnt;
  logic [7:0]     r_cmd_hi;
  logic           r_cmd_second;
  logic [PCW-1:0] r_pay_cnt;
  logic [ICW-1:0] r_idle;
  logic           r_cmd_valid;
  logic [3:0]     r_cmd_id;
  logic           r_cmd_error;
  logic [7:0]     r_payload_data;
  logic           r_payload_valid;
  logic           r_payload_last;
  logic           r_busy;
  logic           r_timeout;

  logic [7:0]     w_hdr_exp;
  logic [15:0]    w_cmd_word;
  logic           w_cmd_legal;

  always_comb begin
    w_hdr_exp = HDR_ALIGN[31:24];
    case (r_hdr_cnt)
      2'd1:    w_hdr_exp = HDR_ALIGN[23:16];
      2'd2:    w_hdr_exp = HDR_ALIGN[15:8];
      2'd3:    w_hdr_exp = HDR_ALIGN[7:0];
      default: w_hdr_exp = HDR_ALIGN[31:24];
    endcase
  end

  assign w_cmd_word  = {r_cmd_hi, rx_data};
  assign w_cmd_legal = (w_cmd_word[11:8] == 4'h0) && (w_cmd_word[15:12] != 4'h0) &&
                       (w_cmd_word[15:12] <= NCMD) && (w_cmd_word[7:0] == CMD_TAG);

  // Reset asserts immediately; release takes effect one edge later.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_rst_sync <= 1'b0;
    else      r_rst_sync <= 1'b1;
  end

  always_ff @(posedge clk or negedge r_rst_sync) begin
    if (!r_rst_sync) begin
      r_state         <= S_HDR;
      r_hdr_cnt       <= '0;
      r_cmd_hi        <= '0;
      r_cmd_second    <= 1'b0;
      r_pay_cnt       <= '0;
      r_idle          <= '0;
      r_cmd_valid     <= 1'b0;
      r_cmd_id        <= '0;
      r_cmd_error     <= 1'b0;
      r_payload_data  <= '0;
      r_payload_valid <= 1'b0;
      r_payload_last  <= 1'b0;
      r_busy          <= 1'b0;
      r_timeout       <= 1'b0;
    end else begin
      r_cmd_valid     <= 1'b0;
      r_cmd_error     <= 1'b0;
      r_payload_valid <= 1'b0;
      r_payload_last  <= 1'b0;
      r_timeout       <= 1'b0;
      if (rx_valid) begin
        r_idle <= '0;
        case (r_state)
          S_HDR: begin
            if (rx_data == w_hdr_exp) begin
              r_busy <= 1'b1;
              if (r_hdr_cnt == HDR_LAST) begin
                r_hdr_cnt <= '0;
                r_state   <= S_CMD;
              end else begin
                r_hdr_cnt <= r_hdr_cnt + 2'd1;
              end
            end else if (rx_data == HDR_FIRST) begin
              r_hdr_cnt <= 2'd1;
              r_busy    <= 1'b1;
            end else begin
              r_hdr_cnt <= '0;
              r_busy    <= 1'b0;
            end
          end
          S_CMD: begin
            if (!r_cmd_second) begin
              r_cmd_hi     <= rx_data;
              r_cmd_second <= 1'b1;
            end else begin
              r_cmd_second <= 1'b0;
              if (w_cmd_legal) begin
                r_cmd_valid <= 1'b1;
                r_cmd_id    <= w_cmd_word[15:12];
                if (PAYLOAD_BYTES == 0) begin
                  r_state <= S_HDR;
                  r_busy  <= 1'b0;
                end else begin
                  r_state <= S_PAYLOAD;
                end
              end else begin
                r_cmd_error <= 1'b1;
                r_state     <= S_HDR;
                r_busy      <= 1'b0;
              end
            end
          end
          S_PAYLOAD: begin
            r_payload_valid <= 1'b1;
            r_payload_data  <= rx_data;
            if (r_pay_cnt == PAY_LAST) begin
              r_payload_last <= 1'b1;
              r_pay_cnt      <= '0;
              r_state        <= S_HDR;
              r_busy         <= 1'b0;
            end else begin
              r_pay_cnt <= r_pay_cnt + PCW'(1);
            end
          end
          default: r_state <= S_HDR;
        endcase
      end else if ((TIMEOUT_CYCLES != 0) && r_busy) begin
        if (r_idle == IDLE_LAST) begin
          r_timeout    <= 1'b1;
          r_state      <= S_HDR;
          r_hdr_cnt    <= '0;
          r_cmd_second <= 1'b0;
          r_pay_cnt    <= '0;
          r_idle       <= '0;
          r_busy       <= 1'b0;
        end else begin
          r_idle <= r_idle + ICW'(1);
        end
      end
    end
  end

  assign cmd_valid     = r_cmd_valid;
  assign cmd_id        = r_cmd_id;
  assign cmd_error     = r_cmd_error;
  assign payload_data  = r_payload_data;
  assign payload_valid = r_payload_valid;
  assign payload_last  = r_payload_last;
  assign busy          = r_busy;
  assign timeout       = r_timeout;

endmodule

// File: tb/tb_uart_command_parser.sv
// Bench for uart_command_parser: two parameterisations share one byte stream and
// are checked every cycle against a frame-level model plus directed scenario totals.
module tb_uart_command_parser;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       rx_valid = 1'b0;
  logic [7:0] rx_data = 8'h00;

  logic       a_cmd_valid, a_cmd_error, a_payload_valid, a_payload_last, a_busy, a_timeout;
  logic [3:0] a_cmd_id;
  logic [7:0] a_payload_data;
  logic       b_cmd_valid, b_cmd_error, b_payload_valid, b_payload_last, b_busy, b_timeout;
  logic [3:0] b_cmd_id;
  logic [7:0] b_payload_data;

  always #5 clk = ~clk;

  uart_command_parser #(
    .HEADER_BYTES(2), .HEADER(16'hCDBA), .CMD_TAG(8'hA0), .NUM_CMDS(6),
    .PAYLOAD_BYTES(1024), .TIMEOUT_CYCLES(50)
  ) u_dut_a (
    .clk(clk), .rst(rst), .rx_data(rx_data), .rx_valid(rx_valid),
    .cmd_valid(a_cmd_valid), .cmd_id(a_cmd_id), .cmd_error(a_cmd_error),
    .payload_data(a_payload_data), .payload_valid(a_payload_valid),
    .payload_last(a_payload_last), .busy(a_busy), .timeout(a_timeout)
  );

  uart_command_parser #(
    .HEADER_BYTES(1), .HEADER(8'h55), .CMD_TAG(8'hA0), .NUM_CMDS(6),
    .PAYLOAD_BYTES(0), .TIMEOUT_CYCLES(20)
  ) u_dut_b (
    .clk(clk), .rst(rst), .rx_data(rx_data), .rx_valid(rx_valid),
    .cmd_valid(b_cmd_valid), .cmd_id(b_cmd_id), .cmd_error(b_cmd_error),
    .payload_data(b_payload_data), .payload_valid(b_payload_valid),
    .payload_last(b_payload_last), .busy(b_busy), .timeout(b_timeout)
  );

  localparam int         NCMD = 6;
  localparam logic [7:0] TAG  = 8'hA0;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // ---------------- reference model (index 0 = A, 1 = B) ----------------
  function automatic int cfg_hb(input int k);  return (k == 0) ? 2 : 1;          endfunction
  function automatic int cfg_hdr(input int k); return (k == 0) ? 'hCDBA : 'h55;  endfunction
  function automatic int cfg_pay(input int k); return (k == 0) ? 1024 : 0;       endfunction
  function automatic int cfg_tmo(input int k); return (k == 0) ? 50 : 20;        endfunction

  function automatic logic [7:0] hdr_byte(input int k, input int i);
    int sh;
    sh = 8 * (cfg_hb(k) - 1 - i);
    return 8'((cfg_hdr(k) >> sh) & 255);
  endfunction

  int         m_hdr_got[2];
  bit         m_in_cmd[2];
  int         m_cmd_n[2];
  logic [7:0] m_cmd_hi[2];
  int         m_pay_left[2];
  int         m_idle[2];
  bit         m_rst_q = 1'b0;

  logic       e_cv[2], e_ce[2], e_pv[2], e_pl[2], e_busy[2], e_to[2];
  logic [3:0] e_id[2];
  logic [7:0] e_pd[2];

  function automatic bit m_busy(input int k);
    return m_in_cmd[k] || (m_pay_left[k] > 0) || (m_hdr_got[k] > 0);
  endfunction

  task automatic m_reset(input int k);
    m_hdr_got[k] = 0; m_in_cmd[k] = 1'b0; m_cmd_n[k] = 0; m_cmd_hi[k] = 8'h00;
    m_pay_left[k] = 0; m_idle[k] = 0;
    e_cv[k] = 1'b0; e_ce[k] = 1'b0; e_pv[k] = 1'b0; e_pl[k] = 1'b0;
    e_busy[k] = 1'b0; e_to[k] = 1'b0; e_id[k] = 4'h0; e_pd[k] = 8'h00;
  endtask

  task automatic m_step(input int k, input logic v, input logic [7:0] d);
    int id;
    e_cv[k] = 1'b0; e_ce[k] = 1'b0; e_pv[k] = 1'b0; e_pl[k] = 1'b0; e_to[k] = 1'b0;
    if (v) begin
      m_idle[k] = 0;
      if (m_pay_left[k] > 0) begin
        e_pv[k] = 1'b1;
        e_pd[k] = d;
        m_pay_left[k]--;
        if (m_pay_left[k] == 0) e_pl[k] = 1'b1;
      end else if (m_in_cmd[k]) begin
        if (m_cmd_n[k] == 0) begin
          m_cmd_hi[k] = d;
          m_cmd_n[k]  = 1;
        end else begin
          id = int'(m_cmd_hi[k]) / 16;
          m_in_cmd[k] = 1'b0;
          m_cmd_n[k]  = 0;
          if ((int'(m_cmd_hi[k]) % 16 == 0) && id >= 1 && id <= NCMD && d == TAG) begin
            e_cv[k] = 1'b1;
            e_id[k] = 4'(id);
            m_pay_left[k] = cfg_pay(k);
          end else begin
            e_ce[k] = 1'b1;
          end
        end
      end else begin
        if (d == hdr_byte(k, m_hdr_got[k])) begin
          m_hdr_got[k]++;
          if (m_hdr_got[k] == cfg_hb(k)) begin
            m_hdr_got[k] = 0;
            m_in_cmd[k]  = 1'b1;
          end
        end else begin
          m_hdr_got[k] = (d == hdr_byte(k, 0)) ? 1 : 0;
        end
      end
    end else if (m_busy(k) && cfg_tmo(k) > 0) begin
      m_idle[k]++;
      if (m_idle[k] == cfg_tmo(k)) begin
        e_to[k] = 1'b1;
        m_hdr_got[k] = 0; m_in_cmd[k] = 1'b0; m_cmd_n[k] = 0;
        m_pay_left[k] = 0; m_idle[k] = 0;
      end
    end
    e_busy[k] = m_busy(k);
  endtask

  // The first edge after reset release is still treated as reset.
  initial begin
    forever begin
      @(posedge clk or negedge rst);
      if (!rst) begin
        m_reset(0); m_reset(1);
        m_rst_q = 1'b0;
      end else begin
        if (!m_rst_q) begin
          m_reset(0); m_reset(1);
        end else begin
          m_step(0, rx_valid, rx_data);
          m_step(1, rx_valid, rx_data);
        end
        m_rst_q = 1'b1;
      end
    end
  end

  // ---------------- observation ----------------
  function automatic logic [31:0] pack_a();
    return {14'd0, a_cmd_valid, a_cmd_id, a_cmd_error, a_payload_valid, a_payload_last,
            a_busy, a_timeout, a_payload_data};
  endfunction
  function automatic logic [31:0] pack_b();
    return {14'd0, b_cmd_valid, b_cmd_id, b_cmd_error, b_payload_valid, b_payload_last,
            b_busy, b_timeout, b_payload_data};
  endfunction
  function automatic logic [31:0] pack_e(input int k);
    return {14'd0, e_cv[k], e_id[k], e_ce[k], e_pv[k], e_pl[k], e_busy[k], e_to[k], e_pd[k]};
  endfunction

  int cyc = 0;
  int n_a_cv = 0, n_a_ce = 0, n_a_pv = 0, n_a_pl = 0, n_a_to = 0, n_b_cv = 0;
  int last_pv_cyc = 0, to_cyc = 0, pv_at_last = 0;
  int s_cv, s_ce, s_pv, s_pl, s_to, s_bcv;
  logic [3:0] b_ids[$];

  task automatic cmp_cycle();
    cyc++;
    check_eq("a_outputs", pack_a(), pack_e(0));
    check_eq("b_outputs", pack_b(), pack_e(1));
    n_a_cv += int'(a_cmd_valid);
    n_a_ce += int'(a_cmd_error);
    n_a_pv += int'(a_payload_valid);
    n_a_pl += int'(a_payload_last);
    n_a_to += int'(a_timeout);
    n_b_cv += int'(b_cmd_valid);
    if (a_payload_valid) last_pv_cyc = cyc;
    if (a_timeout)       to_cyc = cyc;
    if (a_payload_last)  pv_at_last = n_a_pv;
    if (b_cmd_valid)     b_ids.push_back(b_cmd_id);
  endtask

  task automatic snap();
    s_cv = n_a_cv; s_ce = n_a_ce; s_pv = n_a_pv; s_pl = n_a_pl; s_to = n_a_to; s_bcv = n_b_cv;
  endtask

  task automatic tick(input logic v, input logic [7:0] d);
    @(negedge clk);
    cmp_cycle();
    rx_valid = v;
    rx_data  = d;
  endtask

  task automatic gap(input int n);
    repeat (n) tick(1'b0, 8'($urandom));
  endtask

  task automatic send(input logic [7:0] b);
    tick(1'b1, b);
  endtask

  function automatic int rand_gap();
    return ($urandom_range(0, 9) == 0) ? int'($urandom_range(45, 55)) : int'($urandom_range(0, 2));
  endfunction

  initial begin
    int nb;
    int n;
    int g;
    logic [7:0] hi;
    logic [7:0] lo;

    #1;
    check_eq("reset_a", pack_a(), 32'h0);
    check_eq("reset_b", pack_b(), 32'h0);
    gap(3);

    // Release: a CD presented on the first edge must be ignored, the one on the second taken.
    @(negedge clk);
    cmp_cycle();
    rst = 1'b1; rx_valid = 1'b1; rx_data = 8'hCD;
    snap();
    send(8'hCD); send(8'hBA); send(8'h10); send(8'hA0);
    for (int i = 0; i < 1024; i++) send(8'($urandom));
    gap(5);
    check_eq("s1_cmd_valid_cnt", 32'(n_a_cv - s_cv), 32'd1);
    check_eq("s1_cmd_id", 32'(a_cmd_id), 32'd1);
    check_eq("s1_payload_cnt", 32'(n_a_pv - s_pv), 32'd1024);
    check_eq("s1_last_cnt", 32'(n_a_pl - s_pl), 32'd1);
    check_eq("s1_last_pos", 32'(pv_at_last - s_pv), 32'd1024);
    check_eq("s1_busy_after", 32'(a_busy), 32'd0);

    gap(30);
    snap();
    send(8'hCD); send(8'hCD); send(8'hBA); send(8'h50); send(8'hA0);
    gap(60);
    check_eq("s2_resync_cmd_cnt", 32'(n_a_cv - s_cv), 32'd1);
    check_eq("s2_resync_id", 32'(a_cmd_id), 32'd5);

    snap();
    send(8'hCD); send(8'hBA); send(8'h70); send(8'hA0);
    send(8'hCD); send(8'hBA); send(8'h11); send(8'hA0);
    send(8'hCD); send(8'hBA); send(8'h10); send(8'hA1);
    gap(3);
    check_eq("s3_err_cnt", 32'(n_a_ce - s_ce), 32'd3);
    check_eq("s3_cmd_cnt", 32'(n_a_cv - s_cv), 32'd0);
    check_eq("s3_id_kept", 32'(a_cmd_id), 32'd5);

    gap(30);
    snap();
    send(8'hCD); send(8'hBA); send(8'h20); send(8'hA0);
    send(8'h01); send(8'h02); send(8'h03);
    gap(70);
    check_eq("s4_timeout_cnt", 32'(n_a_to - s_to), 32'd1);
    check_eq("s4_timeout_delay", 32'(to_cyc - last_pv_cyc), 32'd50);
    check_eq("s4_no_last", 32'(n_a_pl - s_pl), 32'd0);
    snap();
    send(8'hCD); send(8'hBA); send(8'h30); send(8'hA0);
    gap(3);
    check_eq("s4_next_cmd_cnt", 32'(n_a_cv - s_cv), 32'd1);
    check_eq("s4_next_id", 32'(a_cmd_id), 32'd3);
    gap(60);

    // Bytes landing on the limit cycle must win over the timeout.
    snap();
    send(8'hCD); send(8'hBA); send(8'h40); send(8'hA0);
    send(8'h11); gap(49); send(8'h22); gap(49); send(8'h33);
    gap(60);
    check_eq("s5_edge_timeouts", 32'(n_a_to - s_to), 32'd1);
    check_eq("s5_edge_payload", 32'(n_a_pv - s_pv), 32'd3);
    check_eq("s5_edge_id", 32'(a_cmd_id), 32'd4);

    gap(25);
    snap();
    send(8'h55); send(8'h60); send(8'hA0); send(8'h55); send(8'h10); send(8'hA0);
    gap(3);
    nb = b_ids.size();
    check_eq("s6_b_cmd_cnt", 32'(n_b_cv - s_bcv), 32'd2);
    check_eq("s6_b_id_seq", (nb >= 2) ? {24'd0, b_ids[nb-2], b_ids[nb-1]} : 32'hFFFF, 32'h61);

    gap(25);
    snap();
    send(8'hCD); send(8'hBA); send(8'h10);
    @(negedge clk);
    cmp_cycle();
    rx_valid = 1'b0;
    check_eq("s7_busy_pre", 32'(a_busy), 32'd1);
    #2 rst = 1'b0;
    #1;
    check_eq("s7_rst_async_a", pack_a(), 32'h0);
    check_eq("s7_rst_async_b", pack_b(), 32'h0);
    send(8'hA0);
    gap(2);
    @(negedge clk);
    cmp_cycle();
    rst = 1'b1; rx_valid = 1'b1; rx_data = 8'hA0;
    send(8'hA0);
    gap(5);
    check_eq("s7_no_cmd", 32'(n_a_cv - s_cv), 32'd0);
    check_eq("s7_no_err", 32'(n_a_ce - s_ce), 32'd0);
    check_eq("s7_busy_post", 32'(a_busy), 32'd0);

    for (int it = 0; it < 40; it++) begin
      case ($urandom_range(0, 5))
        0: begin
          n = int'($urandom_range(1, 6));
          for (int j = 0; j < n; j++) begin send(8'($urandom)); gap(int'($urandom_range(0, 2))); end
        end
        1: begin
          hi = {4'($urandom_range(1, 6)), 4'h0};
          send(8'hCD); gap(rand_gap()); send(8'hBA); gap(rand_gap());
          send(hi); gap(rand_gap()); send(8'hA0);
          if ($urandom_range(0, 3) == 0) begin
            for (int j = 0; j < 1024; j++) begin send(8'($urandom)); gap(int'($urandom_range(0, 1))); end
          end else begin
            n = int'($urandom_range(1, 20));
            for (int j = 0; j < n; j++) begin send(8'($urandom)); gap(rand_gap()); end
          end
        end
        2: begin
          hi = 8'($urandom);
          lo = ($urandom_range(0, 1) == 0) ? TAG : 8'($urandom);
          send(8'hCD); send(8'hBA); send(hi); gap(rand_gap()); send(lo);
        end
        3: begin
          hi = {4'($urandom_range(0, 15)), ($urandom_range(0, 2) == 0) ? 4'($urandom) : 4'h0};
          lo = ($urandom_range(0, 3) == 0) ? 8'($urandom) : TAG;
          send(8'h55); gap(rand_gap()); send(hi); gap(rand_gap()); send(lo);
        end
        4: gap(int'($urandom_range(0, 80)));
        default: begin
          send(8'hCD);
          g = rand_gap();
          gap(g);
          send(($urandom_range(0, 1) == 0) ? 8'hCD : 8'($urandom));
          send(8'hBA);
        end
      endcase
    end

    gap(100);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
